// File: rtl/nn_param_pkg.sv
// Shared sizing, slot layout and FSM encoding for the perceptron parameter loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nn_param_pkg;

    localparam int NUM_NEURONS       = 4;
    localparam int NUM_INPUTS        = 4;
    localparam int PARAMS_PER_NEURON = NUM_INPUTS + 2;
    localparam int SLOT_BIAS         = NUM_INPUTS;
    localparam int SLOT_TH           = NUM_INPUTS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Flat byte index of (neuron, slot) inside the parameter vector.
    function automatic int unsigned param_idx(input int unsigned neuron,
                                              input int unsigned slot);
        return neuron * PARAMS_PER_NEURON + slot;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous pin into clk domain and flags its rising edges as one-cycle pulses.
// Latency: pin edge meeting setup shows as rise after the 2nd clk, acted on at the 3rd.
// Backpressure: none; every sampled rising edge produces exactly one pulse.
//
// Ports: clk, reset (async active-high), async_in (raw pin), rise (1-cycle pulse).
module sync_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise = sync2 & ~dly;

endmodule

// File: rtl/nn_param_loader.sv
// Assembles a byte-serial parameter frame, verifies its additive checksum, commits it atomically.
// Latency: params_flat updates 1 clk after the checksum byte is accepted (3 clks after its strobe).
// Backpressure: none; strobes outside LOAD are dropped, a silent LOAD aborts after TIMEOUT_CYCLES.
//
// Ports: clk, reset (async active-high), data_in/strobe/start (async pins),
//        params_flat (active set), params_valid, busy, chk_err, tmo_err, byte_count.
module nn_param_loader #(
    parameter int NUM_NEURONS    = nn_param_pkg::NUM_NEURONS,
    parameter int NUM_INPUTS     = nn_param_pkg::NUM_INPUTS,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [7:0]                                  data_in,
    input  logic                                        strobe,
    input  logic                                        start,
    output logic [8*NUM_NEURONS*(NUM_INPUTS+2)-1:0]     params_flat,
    output logic                                        params_valid,
    output logic                                        busy,
    output logic                                        chk_err,
    output logic                                        tmo_err,
    output logic [4:0]                                  byte_count
);

    import nn_param_pkg::*;

    localparam int NB  = NUM_NEURONS * (NUM_INPUTS + 2);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]    NB_CNT   = 5'(NB);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          strobe_rise;
    logic          start_rise;
    state_t        state;
    logic [8*NB-1:0] shadow;
    logic [7:0]    sum;
    logic [7:0]    checksum;
    logic [TW-1:0] tmo_cnt;

    sync_rise_detect u_strobe_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (strobe),
        .rise     (strobe_rise)
    );

    sync_rise_detect u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (start),
        .rise     (start_rise)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shadow       <= '0;
            params_flat  <= '0;
            params_valid <= 1'b0;
            chk_err      <= 1'b0;
            tmo_err      <= 1'b0;
            byte_count   <= '0;
            sum          <= '0;
            checksum     <= '0;
            tmo_cnt      <= '0;
        end else if (start_rise) begin
            // A start in any state opens a fresh frame; a coincident strobe is
            // deliberately dropped and any pending CHECK is abandoned.
            state      <= LOAD;
            byte_count <= '0;
            sum        <= '0;
            chk_err    <= 1'b0;
            tmo_err    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (strobe_rise) begin
                        tmo_cnt <= '0;
                        if (byte_count != NB_CNT) begin
                            shadow[{byte_count, 3'b000} +: 8] <= data_in;
                            sum        <= sum + data_in;
                            byte_count <= byte_count + 5'd1;
                        end else begin
                            checksum <= data_in;
                            state    <= CHECK;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // Only place the active set ever changes: whole frame or nothing.
                    if (sum == checksum) begin
                        params_flat  <= shadow;
                        params_valid <= 1'b1;
                    end else begin
                        chk_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_param_loader.sv
module tb_nn_param_loader;

    localparam int NB   = 24;
    localparam int TMO  = 100;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      data_in;
    logic            strobe;
    logic            start;
    logic [8*NB-1:0] params_flat;
    logic            params_valid;
    logic            busy;
    logic            chk_err;
    logic            tmo_err;
    logic [4:0]      byte_count;

    int total = 0;
    int bad   = 0;

    // Reference model: frame-level view of the loader.
    logic [7:0] exp_act [NB];
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_chk;
    logic       exp_tmo;
    int         exp_cnt;

    always #5 clk = ~clk;

    nn_param_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .strobe       (strobe),
        .start        (start),
        .params_flat  (params_flat),
        .params_valid (params_valid),
        .busy         (busy),
        .chk_err      (chk_err),
        .tmo_err      (tmo_err),
        .byte_count   (byte_count)
    );

    task automatic chk_eq(input string tag, input logic [8*NB-1:0] got,
                          input logic [8*NB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] exp_flat();
        logic [8*NB-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = exp_act[k];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk_eq({tag, "/flat"},  params_flat, exp_flat());
        chk_eq({tag, "/valid"}, (8*NB)'(params_valid), (8*NB)'(exp_valid));
        chk_eq({tag, "/busy"},  (8*NB)'(busy),         (8*NB)'(exp_busy));
        chk_eq({tag, "/chk"},   (8*NB)'(chk_err),      (8*NB)'(exp_chk));
        chk_eq({tag, "/tmo"},   (8*NB)'(tmo_err),      (8*NB)'(exp_tmo));
        chk_eq({tag, "/cnt"},   (8*NB)'(byte_count),   (8*NB)'(exp_cnt));
    endtask

    // Pin-level drivers: each edge is held well past the synchroniser latency.
    task automatic pulse_strobe(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        strobe  = 1'b1;
        repeat (4) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Model events.
    task automatic model_start();
        exp_busy = 1'b1;
        exp_chk  = 1'b0;
        exp_tmo  = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic model_frame(input logic [7:0] fr [NB], input logic [7:0] cks);
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) s += fr[k];
        exp_cnt  = NB;
        exp_busy = 1'b0;
        if ((s % 256) == cks) begin
            for (int k = 0; k < NB; k++) exp_act[k] = fr[k];
            exp_valid = 1'b1;
        end else begin
            exp_chk = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] fr [NB], input logic [7:0] cks);
        pulse_start();
        model_start();
        for (int k = 0; k < NB; k++) pulse_strobe(fr[k]);
        pulse_strobe(cks);
        model_frame(fr, cks);
    endtask

    function automatic logic [7:0] frame_sum(input logic [7:0] fr [NB]);
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) s += fr[k];
        return 8'(s);
    endfunction

    initial begin
        logic [7:0] fr [NB];
        logic [7:0] cks;
        int         npart;

        reset   = 1'b1;
        data_in = 8'h00;
        strobe  = 1'b0;
        start   = 1'b0;
        for (int k = 0; k < NB; k++) exp_act[k] = 8'h00;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_chk   = 1'b0;
        exp_tmo   = 1'b0;
        exp_cnt   = 0;

        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Strobes while idle are ignored.
        for (int i = 0; i < 3; i++) pulse_strobe(8'h5A);
        check_all("idle_strobe");

        // Good frame 1..24, checksum 0x2C, with cycle-exact commit check.
        pulse_start();
        model_start();
        for (int k = 0; k < NB; k++) begin
            fr[k] = 8'(k + 1);
            pulse_strobe(fr[k]);
        end
        data_in = 8'h2C;
        strobe  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("cks_accept/busy",  (8*NB)'(busy),         (8*NB)'(1));
        chk_eq("cks_accept/valid", (8*NB)'(params_valid), (8*NB)'(0));
        chk_eq("cks_accept/flat",  params_flat,           '0);
        @(posedge clk);
        #1;
        model_frame(fr, 8'h2C);
        check_all("good_commit");
        chk_eq("good/w00", (8*NB)'(params_flat[7:0]),     (8*NB)'(8'h01));
        chk_eq("good/b0",  (8*NB)'(params_flat[39:32]),   (8*NB)'(8'h05));
        chk_eq("good/th3", (8*NB)'(params_flat[191:184]), (8*NB)'(8'h18));
        @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);

        // Bad checksum: all 0xFF, checksum 0x00 (true sum 0xE8).
        for (int k = 0; k < NB; k++) fr[k] = 8'hFF;
        chk_eq("bad/sum_ref", (8*NB)'(frame_sum(fr)), (8*NB)'(8'hE8));
        run_frame(fr, 8'h00);
        check_all("bad_cks");

        // Timeout after 5 bytes.
        pulse_start();
        model_start();
        for (int k = 0; k < 5; k++) pulse_strobe(8'(8'h30 + k));
        exp_cnt = 5;
        repeat (80) @(negedge clk);
        check_all("tmo_pending");
        repeat (40) @(negedge clk);
        exp_tmo  = 1'b1;
        exp_busy = 1'b0;
        check_all("tmo_fired");

        // Restart mid-frame: 0xAA bytes must never reach the active set.
        pulse_start();
        model_start();
        for (int k = 0; k < 10; k++) pulse_strobe(8'hAA);
        for (int k = 0; k < NB; k++) fr[k] = 8'h10;
        run_frame(fr, 8'h80);
        check_all("restart");

        // Coincident start and strobe edges during LOAD: start wins.
        pulse_start();
        model_start();
        pulse_strobe(8'h77);
        pulse_strobe(8'h78);
        @(negedge clk);
        data_in = 8'h99;
        start   = 1'b1;
        strobe  = 1'b1;
        repeat (4) @(negedge clk);
        start  = 1'b0;
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        exp_cnt = 0;
        check_all("simul_edges");
        for (int k = 0; k < NB; k++) begin
            fr[k] = 8'($urandom_range(0, 255));
            pulse_strobe(fr[k]);
        end
        pulse_strobe(frame_sum(fr));
        model_frame(fr, frame_sum(fr));
        check_all("simul_finish");

        // Randomised frames: random data, sometimes a corrupted checksum,
        // sometimes an abandoned partial frame first.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NB; k++) fr[k] = 8'($urandom_range(0, 255));
            cks = frame_sum(fr);
            if ($urandom_range(0, 1) == 1) cks = cks + 8'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) begin
                pulse_start();
                model_start();
                npart = $urandom_range(1, NB - 1);
                for (int k = 0; k < npart; k++) pulse_strobe(8'($urandom_range(0, 255)));
            end
            run_frame(fr, cks);
            check_all($sformatf("rand%0d", f));
        end

        // Async reset mid-frame after a commit.
        for (int k = 0; k < NB; k++) fr[k] = 8'(k + 1);
        run_frame(fr, frame_sum(fr));
        pulse_start();
        model_start();
        for (int k = 0; k < 12; k++) pulse_strobe(8'h3C);
        exp_cnt = 12;
        check_all("pre_reset");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NB; k++) exp_act[k] = 8'h00;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_chk   = 1'b0;
        exp_tmo   = 1'b0;
        exp_cnt   = 0;
        check_all("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulse_strobe(8'h11);
        pulse_strobe(8'h22);
        check_all("post_reset_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
